dispensador_lotes: RTL and testbench
====================================

Name: dispensador_lotes

Overview:
- Parametrised successor of the single-purpose cork dispenser.
- Tracks dispenser stock in individual corks, not in 20-cork units. Serves tray refill requests from fsm_dispensador in batches of BATCH.
- Supports an external reload of the dispenser, optional partial last batch, low-stock and empty flags, and a pending-request flag.
- Sits between fsm_dispensador (request side) and the tray module (consumes reabastecer/lote).

Parameters:
- WIDTH, 7, width of the stock count and lote; CAPACITY must be < 2**WIDTH.
- CAPACITY, 100, stock after reset and after recarga.
- BATCH, 20, corks per normal delivery; 1 <= BATCH <= CAPACITY.
- LOW_MARK, 20, baixo asserts when estoque <= LOW_MARK.
- PARCIAL, 0, 1 = deliver the remainder when 0 < estoque < BATCH; 0 = refuse until recarga.
- CNT_WIDTH, 8, width of the delivered-batch counter (wraps).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ativar  in  1  level request from fsm_dispensador (tray down to 5 corks).
- recarga  in  1  one-cycle pulse: dispenser physically reloaded to CAPACITY.
- reabastecer  out  1  one-cycle pulse: batch delivered to tray.
- lote  out  WIDTH  corks in the current/last delivery; held until the next delivery.
- estoque  out  WIDTH  current corks in the dispenser.
- vazio  out  1  estoque == 0.
- baixo  out  1  estoque <= LOW_MARK.
- pendente  out  1  a request is blocked by insufficient stock.
- entregas  out  CNT_WIDTH  count of completed deliveries, wraps modulo 2**CNT_WIDTH.

Behaviour:
- Reset (async, immediate on rst high, any state):
  - state=IDLE, estoque=CAPACITY, lote=0, reabastecer=0, pendente=0, entregas=0.
  - vazio=0, baixo=(CAPACITY<=LOW_MARK).
- All outputs are registered. vazio and baixo are derived from the registered estoque.
- "Pode" (may serve) = estoque >= BATCH, or (PARCIAL==1 and estoque > 0). The amount served n = min(estoque, BATCH).
- FSM states:
  - IDLE:
    - ativar=1 and pode: at this edge reabastecer<=1, lote<=n, estoque<=estoque-n, entregas<=entregas+1, pendente<=0, go ENTREGA. Latency is one cycle from ativar sampled high to reabastecer high.
    - ativar=1 and not pode: pendente<=1, stay IDLE.
    - ativar=0: pendente<=0.
  - ENTREGA: reabastecer<=0 at the next edge; go ESPERA.
  - ESPERA: stay while ativar=1; go IDLE on the first edge with ativar=0.
    - Guarantees exactly one batch per request assertion, however long ativar is held.
- recarga:
  - Sets estoque<=CAPACITY on the sampling edge, in any state.
  - If the same edge performs a delivery (IDLE serve), estoque<=CAPACITY-n, where n is computed from the pre-edge estoque. Pode is evaluated on pre-edge estoque, so a blocked request is served on the edge after recarga, not the same one.
- Blocked request with ativar held:
  - pendente stays 1.
  - After recarga, the next edge serves it normally and clears pendente.
- estoque never underflows; decrement occurs only when pode is true.
- entregas wraps from all-ones to 0 without affecting other state.
- rst asserted during ENTREGA/ESPERA: reabastecer drops immediately; no partial update survives.

Decomposition:
- Shared package/header dispensador_pkg holds:
  - FSM state encoding localparams ST_IDLE=2'd0, ST_ENTREGA=2'd1, ST_ESPERA=2'd2.
  - Default CAPACITY/BATCH constants shared with the tray and fsm_dispensador.
- One natural sub-module: estoque_contador, the load/subtract stock register with async reset to CAPACITY. Its inputs are load (recarga), sub (serve), n. Its output is estoque.
- The FSM, lote/entregas registers and flags stay in the top module.

Test Plan:
- Defaults, rst pulse, ativar high 4 cycles -> single reabastecer pulse one cycle after first sample. lote=20, estoque=80, entregas=1; no second pulse until ativar drops and rises again.
- Five request/release cycles -> estoque 80,60,40,20,0. baixo=1 after 4th (20), vazio=1 after 5th. 6th ativar -> no pulse, pendente=1.
- Continue holding ativar after 6th request, pulse recarga -> estoque=100 next edge. reabastecer one edge later, estoque=80, pendente=0, entregas=6.
- PARCIAL=1, CAPACITY=50 -> deliveries lote=20,20,10, estoque 30,10,0. 4th request -> pendente=1. With PARCIAL=0, 3rd request blocks at estoque=10.
- recarga on the same edge as an IDLE serve with estoque=40 -> estoque=80, lote=20.
- rst raised mid-ESPERA (asynchronous, between edges) -> reabastecer/pendente/entregas=0 and estoque=100 immediately. With ativar still high after rst release, a new delivery occurs.

Source files
------------

// File: rtl/dispensador_pkg.sv
// Shared constants for the cork dispenser family: FSM encoding and default
// capacity and batch values used by the tray, fsm_dispensador and this block.
package dispensador_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENTREGA = 2'd1;
  localparam logic [1:0] ST_ESPERA  = 2'd2;

  localparam int DEF_CAPACITY = 100;
  localparam int DEF_BATCH    = 20;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ENTREGA = ST_ENTREGA,
    ESPERA  = ST_ESPERA
  } estado_t;

endpackage

// File: rtl/estoque_contador.sv
// Stock register for the dispenser. A reload restores CAPACITY; a serve
// subtracts n. When both happen on the same edge, the serve applies to the
// freshly reloaded stock.
module estoque_contador import dispensador_pkg::*; #(
  parameter int WIDTH    = 7,
  parameter int CAPACITY = DEF_CAPACITY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] estoque
);

  localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);

  // Load/subtract stock register; it resets to a full dispenser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estoque <= CAP_W;
    end else if (load && sub) begin
      estoque <= CAP_W - n;
    end else if (load) begin
      estoque <= CAP_W;
    end else if (sub) begin
      estoque <= estoque - n;
    end
  end

endmodule

// File: rtl/dispensador_lotes.sv
// Batch dispenser: serves tray refill requests from fsm_dispensador in
// batches of BATCH corks. It tracks stock per cork, accepts external reloads
// and reports low, empty and blocked-request status.
module dispensador_lotes import dispensador_pkg::*; #(
  parameter int WIDTH     = 7,
  parameter int CAPACITY  = DEF_CAPACITY,
  parameter int BATCH     = DEF_BATCH,
  parameter int LOW_MARK  = 20,
  parameter int PARCIAL   = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ativar,
  input  logic                 recarga,
  output logic                 reabastecer,
  output logic [WIDTH-1:0]     lote,
  output logic [WIDTH-1:0]     estoque,
  output logic                 vazio,
  output logic                 baixo,
  output logic                 pendente,
  output logic [CNT_WIDTH-1:0] entregas
);

  localparam logic [WIDTH-1:0] BATCH_W = WIDTH'(BATCH);
  localparam logic [WIDTH-1:0] LOW_W   = WIDTH'(LOW_MARK);

  estado_t          estado;
  logic             pode;
  logic             servir;
  logic [WIDTH-1:0] n;

  // Decide whether a request can be served, and how many corks to hand out,
  // based on the stock held before the current edge.
  always_comb begin
    pode   = (estoque >= BATCH_W) || ((PARCIAL != 0) && (estoque != '0));
    n      = (estoque < BATCH_W) ? estoque : BATCH_W;
    servir = (estado == IDLE) && ativar && pode;
  end

  estoque_contador #(
    .WIDTH    (WIDTH),
    .CAPACITY (CAPACITY)
  ) u_estoque (
    .clk     (clk),
    .rst     (rst),
    .load    (recarga),
    .sub     (servir),
    .n       (n),
    .estoque (estoque)
  );

  // Status flags are taken straight from the registered stock count.
  always_comb begin
    vazio = (estoque == '0);
    baixo = (estoque <= LOW_W);
  end

  // Request FSM. It serves one batch per assertion of ativar and then waits
  // for ativar to drop before it accepts another request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= IDLE;
      reabastecer <= 1'b0;
      lote        <= '0;
      pendente    <= 1'b0;
      entregas    <= '0;
    end else begin
      case (estado)
        IDLE: begin
          reabastecer <= 1'b0;
          if (ativar && pode) begin
            reabastecer <= 1'b1;
            lote        <= n;
            entregas    <= entregas + 1'b1;
            pendente    <= 1'b0;
            estado      <= ENTREGA;
          end else if (ativar) begin
            pendente <= 1'b1;
          end else begin
            pendente <= 1'b0;
          end
        end
        ENTREGA: begin
          reabastecer <= 1'b0;
          estado      <= ESPERA;
        end
        ESPERA: begin
          reabastecer <= 1'b0;
          if (!ativar) begin
            estado <= IDLE;
          end
        end
        default: begin
          reabastecer <= 1'b0;
          estado      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispensador_lotes.sv
// Directed testbench for dispensador_lotes. It uses one default instance and
// two CAPACITY=50 instances (partial and non-partial) driven in lockstep.
module tb_dispensador_lotes;

  logic       clk;
  logic       rst;
  logic       ativar;
  logic       recarga;
  logic       ativar2;

  logic       reabA, vazioA, baixoA, pendA;
  logic [6:0] loteA, estA;
  logic [7:0] entA;

  logic       reabB, vazioB, baixoB, pendB;
  logic [6:0] loteB, estB;
  logic [7:0] entB;

  logic       reabC, vazioC, baixoC, pendC;
  logic [6:0] loteC, estC;
  logic [7:0] entC;

  int total;
  int bad;

  dispensador_lotes dutA (
    .clk(clk), .rst(rst), .ativar(ativar), .recarga(recarga),
    .reabastecer(reabA), .lote(loteA), .estoque(estA), .vazio(vazioA),
    .baixo(baixoA), .pendente(pendA), .entregas(entA)
  );

  dispensador_lotes #(.CAPACITY(50), .PARCIAL(1)) dutB (
    .clk(clk), .rst(rst), .ativar(ativar2), .recarga(1'b0),
    .reabastecer(reabB), .lote(loteB), .estoque(estB), .vazio(vazioB),
    .baixo(baixoB), .pendente(pendB), .entregas(entB)
  );

  dispensador_lotes #(.CAPACITY(50), .PARCIAL(0)) dutC (
    .clk(clk), .rst(rst), .ativar(ativar2), .recarga(1'b0),
    .reabastecer(reabC), .lote(loteC), .estoque(estC), .vazio(vazioC),
    .baixo(baixoC), .pendente(pendC), .entregas(entC)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // Drive inputs, then advance to 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic a, input logic r, input logic a2);
    ativar  = a;
    recarga = r;
    ativar2 = a2;
    @(posedge clk);
    #1;
  endtask

  // One full request/release cycle on instance A with its expected stock.
  task automatic requestA(input string tag, input int expEst);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_reab"}, 32'(reabA), 32'd1);
    checkOutput({tag, "_est"}, 32'(estA), 32'(expEst));
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    ativar  = 1'b0;
    recarga = 1'b0;
    ativar2 = 1'b0;
    #12;
    checkOutput("rst_est", 32'(estA), 32'd100);
    checkOutput("rst_lote", 32'(loteA), 32'd0);
    checkOutput("rst_reab", 32'(reabA), 32'd0);
    checkOutput("rst_pend", 32'(pendA), 32'd0);
    checkOutput("rst_ent", 32'(entA), 32'd0);
    checkOutput("rst_vazio", 32'(vazioA), 32'd0);
    checkOutput("rst_baixo", 32'(baixoA), 32'd0);
    rst = 1'b0;

    // First request, ativar held four sampled edges: exactly one pulse.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("r1_reab", 32'(reabA), 32'd1);
    checkOutput("r1_lote", 32'(loteA), 32'd20);
    checkOutput("r1_est", 32'(estA), 32'd80);
    checkOutput("r1_ent", 32'(entA), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("r1_hold_reab", 32'(reabA), 32'd0);
    end
    checkOutput("r1_hold_ent", 32'(entA), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Drain the dispenser.
    requestA("r2", 60);
    requestA("r3", 40);
    checkOutput("r3_baixo", 32'(baixoA), 32'd0);
    requestA("r4", 20);
    checkOutput("r4_baixo", 32'(baixoA), 32'd1);
    checkOutput("r4_vazio", 32'(vazioA), 32'd0);
    requestA("r5", 0);
    checkOutput("r5_vazio", 32'(vazioA), 32'd1);
    checkOutput("r5_ent", 32'(entA), 32'd5);

    // Sixth request is blocked; then a reload releases it one edge later.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("r6_reab", 32'(reabA), 32'd0);
    checkOutput("r6_pend", 32'(pendA), 32'd1);
    checkOutput("r6_est", 32'(estA), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("r6_pend_hold", 32'(pendA), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rec_est", 32'(estA), 32'd100);
    checkOutput("rec_reab", 32'(reabA), 32'd0);
    checkOutput("rec_pend", 32'(pendA), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("r6_srv_reab", 32'(reabA), 32'd1);
    checkOutput("r6_srv_est", 32'(estA), 32'd80);
    checkOutput("r6_srv_pend", 32'(pendA), 32'd0);
    checkOutput("r6_srv_ent", 32'(entA), 32'd6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reload on the same edge as a serve with 40 corks in stock.
    requestA("r7", 60);
    requestA("r8", 40);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("same_reab", 32'(reabA), 32'd1);
    checkOutput("same_est", 32'(estA), 32'd80);
    checkOutput("same_lote", 32'(loteA), 32'd20);
    checkOutput("same_ent", 32'(entA), 32'd9);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Asynchronous reset while the delivery pulse is high.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_reab", 32'(reabA), 32'd1);
    checkOutput("pre_rst_est", 32'(estA), 32'd60);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reab", 32'(reabA), 32'd0);
    checkOutput("async_est", 32'(estA), 32'd100);
    checkOutput("async_ent", 32'(entA), 32'd0);
    checkOutput("async_pend", 32'(pendA), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_reab", 32'(reabA), 32'd1);
    checkOutput("post_rst_est", 32'(estA), 32'd80);
    checkOutput("post_rst_ent", 32'(entA), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Delivery counter wrap: 255 more deliveries bring it from 1 to 0.
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("wrap_ent", 32'(entA), 32'd0);
    checkOutput("wrap_est", 32'(estA), 32'd80);
    checkOutput("wrap_lote", 32'(loteA), 32'd20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap_next_ent", 32'(entA), 32'd1);
    checkOutput("wrap_next_est", 32'(estA), 32'd60);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // CAPACITY=50: partial vs non-partial last batch.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("p1_lote", 32'(loteB), 32'd20);
    checkOutput("p1_est", 32'(estB), 32'd30);
    checkOutput("n1_est", 32'(estC), 32'd30);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("p2_est", 32'(estB), 32'd10);
    checkOutput("n2_est", 32'(estC), 32'd10);
    checkOutput("p2_baixo", 32'(baixoB), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("p3_reab", 32'(reabB), 32'd1);
    checkOutput("p3_lote", 32'(loteB), 32'd10);
    checkOutput("p3_est", 32'(estB), 32'd0);
    checkOutput("p3_vazio", 32'(vazioB), 32'd1);
    checkOutput("n3_reab", 32'(reabC), 32'd0);
    checkOutput("n3_pend", 32'(pendC), 32'd1);
    checkOutput("n3_est", 32'(estC), 32'd10);
    checkOutput("n3_lote", 32'(loteC), 32'd20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("n3_release_pend", 32'(pendC), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("p4_reab", 32'(reabB), 32'd0);
    checkOutput("p4_pend", 32'(pendB), 32'd1);
    checkOutput("p4_ent", 32'(entB), 32'd3);
    checkOutput("n4_ent", 32'(entC), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
